div_seq: RTL

- Iterative radix-2 restoring divider: the multi-cycle, parametrised successor to the team's combinational 32-bit signed divider.
- Supports signed (truncating) and unsigned division, selected per operation.
- Uses valid/ready handshakes on both the request and result sides.
- Defines results for divide-by-zero and signed overflow, and supports flush.
- Intended as the divide unit behind the core's M-extension execute stage.

---
 rtl/div_seq.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider, signed (truncating) or unsigned per request.
// One quotient bit per cycle; valid/ready on both sides; flush aborts any operation.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] dived,
  input  logic [WIDTH-1:0] divor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quoti,
  output logic [WIDTH-1:0] remai,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_r, state_nxt_s;

  logic [WIDTH-1:0] rem_r, quo_r, dvs_r;
  logic [WIDTH-1:0] quoti_r, remai_r;
  logic [CNT_W-1:0] cnt_r;
  logic             qneg_r, rneg_r;
  logic             out_valid_r, busy_r;

  logic             in_ready_s, accept_s, div_zero_s, ovf_s;
  logic [WIDTH:0]   partial_s, diff_s;
  logic [WIDTH-1:0] rem_nxt_s, quo_nxt_s;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? neg(v) : v;
  endfunction

  assign in_ready_s = (state_r == IDLE) && !flush;
  assign accept_s   = in_valid && in_ready_s;
  assign div_zero_s = (divor == ZERO_W);
  assign ovf_s      = in_signed && (dived == MOST_NEG) && (divor == ALL_ONES);

  // One restoring step; a clear bit WIDTH means the trial subtraction did not go negative
  always_comb begin
    partial_s = {rem_r, quo_r[WIDTH-1]};
    diff_s    = partial_s - {1'b0, dvs_r};
    rem_nxt_s = partial_s[WIDTH-1:0];
    quo_nxt_s = {quo_r[WIDTH-2:0], 1'b0};
    if (!diff_s[WIDTH]) begin
      rem_nxt_s = diff_s[WIDTH-1:0];
      quo_nxt_s = {quo_r[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt_s = partial_s[WIDTH-1:0];
    end
  end

  // Next-state logic; flush overrides every state
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_nxt_s = (div_zero_s || ovf_s) ? DONE : CALC;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        CALC: begin
          if (cnt_r == LAST_CNT) begin
            state_nxt_s = FIX;
          end else begin
            state_nxt_s = CALC;
          end
        end
        FIX: state_nxt_s = DONE;
        DONE: begin
          if (out_ready) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = DONE;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State register with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      out_valid_r <= (state_nxt_s == DONE);
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r   <= ZERO_W;
      quo_r   <= ZERO_W;
      dvs_r   <= ZERO_W;
      cnt_r   <= {CNT_W{1'b0}};
      qneg_r  <= 1'b0;
      rneg_r  <= 1'b0;
      quoti_r <= ZERO_W;
      remai_r <= ZERO_W;
    end else if (flush) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      rem_r  <= ZERO_W;
      quo_r  <= mag(dived, in_signed);
      dvs_r  <= mag(divor, in_signed);
      cnt_r  <= {CNT_W{1'b0}};
      qneg_r <= in_signed && (dived[WIDTH-1] ^ divor[WIDTH-1]);
      rneg_r <= in_signed && dived[WIDTH-1];
      // Special cases bypass the iteration and publish their result immediately
      if (div_zero_s) begin
        quoti_r <= ALL_ONES;
        remai_r <= dived;
      end else if (ovf_s) begin
        quoti_r <= dived;
        remai_r <= ZERO_W;
      end else begin
        quoti_r <= quoti_r;
        remai_r <= remai_r;
      end
    end else begin
      case (state_r)
        CALC: begin
          rem_r <= rem_nxt_s;
          quo_r <= quo_nxt_s;
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        FIX: begin
          quoti_r <= qneg_r ? neg(quo_r) : quo_r;
          remai_r <= rneg_r ? neg(rem_r) : rem_r;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign quoti     = quoti_r;
  assign remai     = remai_r;

endmodule
